lzrw1_group_packer: RTL and testbench
=====================================

// Module: lzrw1_group_packer
// PURPOSE
//  Downstream stage of the compressed-value collector. Accepts LZRW1 items one at a time:
//   literal = 1 byte; copy = 2 bytes {len[3:0],off[11:8]},{off[7:0]}.
//  Buffers up to GROUP_ITEMS items, then emits a byte stream: 16-bit control word (LSB byte first,
//   bit i = 1 if item i is a copy), followed by the item bytes in arrival order.
//  flush closes a partial group and ends the stream with out_last plus a sticky done.
// PARAMETERS
//  GROUP_ITEMS  16  items per control group; fixed by the format, 16-bit control word
//  CNT_W        16  width of bytes_emitted counter
// PORTS
//  clock          in   1      rising-edge clock
//  reset          in   1      asynchronous, active-low (0 = reset)
//  item_valid     in   1      item present
//  item_ready     out  1      packer can take an item
//  item_is_copy   in   1      1 = copy item, 0 = literal
//  item_length    in   4      copy length code (ignored for literals)
//  item_offset    in   12     copy offset (ignored for literals)
//  item_literal   in   8      literal byte (ignored for copies)
//  flush          in   1      end of input; level, sampled in FILL
//  out_valid      out  1      out_data valid
//  out_ready      in   1      consumer takes byte
//  out_data       out  8      stream byte
//  out_last       out  1      final byte of the stream
//  done           out  1      sticky; stream complete
//  bytes_emitted  out  CNT_W  bytes transferred since reset; saturates at all-ones
// BEHAVIOUR
//  Reset (async assert, sync release): state=FILL, count=0, ctrl=0.
//   Output reset values: out_valid=0, out_data=0, out_last=0, done=0, bytes_emitted=0.
//   item_ready is 1 after release.
//  States and transitions:
//   FILL: item_ready=1. An item is taken when item_valid&&item_ready.
//    It is stored at slot[count]; ctrl[count]=item_is_copy; count++.
//    Go to CTRL_LO when count reaches GROUP_ITEMS, or when flush=1 and (count+accept)>0.
//    flush=1 with an empty buffer and no accept -> DONE; no bytes are emitted.
//   CTRL_LO: emit ctrl[7:0].  CTRL_HI: emit ctrl[15:8].
//   ITEM_B0: emit byte0 of slot[rd]; copy -> ITEM_B1, literal -> next slot.
//   ITEM_B1: emit {off[7:0]}; then next slot.
//   After the last slot: if flush is latched -> DONE; else clear count, rd and ctrl, and go to FILL.
//   DONE: terminal. item_ready=0, out_valid=0, done=1; held until reset.
//  Timing and handshakes:
//   Latency: the item that completes a group is accepted in cycle N; out_valid=1 with ctrl[7:0]
//    in cycle N+1.
//   Each emit state advances only on out_valid&&out_ready: one byte per cycle at full rate.
//   While out_valid=1 && out_ready=0, out_data and out_last are held stable.
//   item_ready=0 in every state except FILL; no input is taken during drain.
//  Boundary and corner cases:
//   flush in the same cycle as an accept: the item is included in the closing group.
//   flush is latched when it causes the FILL exit. Its value during drain is ignored.
//   A partial group leaves the unused ctrl bits at 0; only count items are emitted.
//   out_last=1 only on the final byte of the final (flushed) group; never on an unflushed group.
//   A full group of 16 closed by flush ends with out_last on its final byte.
//   Bytes per group = 2 + sum over items (literal 1, copy 2). Maximum is 34.
//   bytes_emitted increments on each out handshake and saturates, no wrap.
//   Reset mid-drain: outputs are forced to reset values immediately and buffered items are lost.
// STRUCTURE
//  Package lzrw1_pkg:
//   constants GROUP_ITEMS=16, CTRL_BYTES=2
//   typedef lzrw1_item_t packed {is_copy, len[3:0], off[11:0], lit[7:0]}
//   typedef enum packer_state_t {FILL, CTRL_LO, CTRL_HI, ITEM_B0, ITEM_B1, DONE}
//  Sub-module lzrw1_item_buffer: GROUP_ITEMS x lzrw1_item_t register file.
//   It has a write pointer, a read pointer and a clear input.
//   The FSM, ctrl word, output mux and counters live in the top module.
// TESTING
//  1. 16 literals 0x41..0x50, out_ready=1 -> 00,00,41..50. No out_last.
//     ctrl[7:0]=00 appears the cycle after the 16th accept.
//  2. Copy(len=3,off=0x123) followed by 15 literals 0x61.. -> 01,00,31,23,61..6F. 19 bytes.
//  3. Five items L,C(2,0x0AB),L,L,C(F,0xFFF), then flush -> 12,00,L,20,AB,L,L,FF,FF.
//     out_last is on the final FF; done=1 the next cycle and stays 1.
//  4. Test 1 repeated with out_ready toggling 1,0,1,0 -> identical byte sequence.
//     Data is held while stalled; item_ready=0 throughout the drain; bytes_emitted=18.
//  5. flush=1 right after reset with no items -> no out_valid; done=1 next cycle.
//  6. Assert reset during CTRL_HI -> out_valid=0 immediately.
//     After release, test 2 runs cleanly with bytes_emitted counting from 0.

Source files
------------

// File: rtl/lzrw1_pkg.sv
// Shared types and constants for the LZRW1 group packer.
package lzrw1_pkg;

  localparam int GROUP_ITEMS = 16;
  localparam int CTRL_BYTES  = 2;
  localparam int PTR_W       = $clog2(GROUP_ITEMS) + 1;
  localparam logic [PTR_W-1:0] GROUP_CNT = PTR_W'(GROUP_ITEMS);

  typedef struct packed {
    logic        is_copy;
    logic [3:0]  len;
    logic [11:0] off;
    logic [7:0]  lit;
  } lzrw1_item_t;

  typedef enum logic [2:0] {
    FILL    = 3'd0,
    CTRL_LO = 3'd1,
    CTRL_HI = 3'd2,
    ITEM_B0 = 3'd3,
    ITEM_B1 = 3'd4,
    DONE    = 3'd5
  } packer_state_t;

endpackage

// File: rtl/lzrw1_item_buffer.sv
// Group-sized item register file with write/read pointers; the write pointer doubles as the item count.
module lzrw1_item_buffer
  import lzrw1_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  lzrw1_item_t      wr_data,
  input  logic             rd_adv,
  output lzrw1_item_t      rd_data,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr
);

  lzrw1_item_t      slots_q [GROUP_ITEMS];
  lzrw1_item_t      slots_d [GROUP_ITEMS];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    slots_d  = slots_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en && (wr_ptr_q < GROUP_CNT)) begin
        slots_d[wr_ptr_q[PTR_W-2:0]] = wr_data;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_adv) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < GROUP_ITEMS; i++) slots_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      slots_q  <= slots_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rd_data = slots_q[rd_ptr_q[PTR_W-2:0]];
  assign wr_ptr  = wr_ptr_q;
  assign rd_ptr  = rd_ptr_q;

endmodule

// File: rtl/lzrw1_group_packer.sv
// Collects LZRW1 items into groups of 16 and streams them out as control word + item bytes.
// state   | meaning
// FILL    | accepting items into the buffer
// CTRL_LO | emitting control word bits 7:0
// CTRL_HI | emitting control word bits 15:8
// ITEM_B0 | emitting literal byte or copy {len, off[11:8]}
// ITEM_B1 | emitting copy off[7:0]
// DONE    | stream finished, held until reset
module lzrw1_group_packer
  import lzrw1_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             item_valid,
  output logic             item_ready,
  input  logic             item_is_copy,
  input  logic [3:0]       item_length,
  input  logic [11:0]      item_offset,
  input  logic [7:0]       item_literal,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             done,
  output logic [CNT_W-1:0] bytes_emitted
);

  packer_state_t    state_q, state_d;
  logic [15:0]      ctrl_q, ctrl_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept, hs, last_slot;
  logic             buf_clear, buf_rd_adv;
  logic [PTR_W-1:0] count, rd_ptr, count_next;
  lzrw1_item_t      wr_item, rd_item;

  assign wr_item = '{is_copy: item_is_copy, len: item_length, off: item_offset, lit: item_literal};

  lzrw1_item_buffer u_buf (
    .clock   (clock),
    .reset   (reset),
    .clear   (buf_clear),
    .wr_en   (accept),
    .wr_data (wr_item),
    .rd_adv  (buf_rd_adv),
    .rd_data (rd_item),
    .wr_ptr  (count),
    .rd_ptr  (rd_ptr)
  );

  assign item_ready = (state_q == FILL);
  assign accept     = item_valid && item_ready;
  assign count_next = count + PTR_W'(accept);
  assign last_slot  = ((rd_ptr + PTR_W'(1)) == count);
  assign hs         = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    flush_d    = flush_q;
    buf_clear  = 1'b0;
    buf_rd_adv = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    out_last   = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) ctrl_d[count[PTR_W-2:0]] = item_is_copy;
        if (count_next == GROUP_CNT) begin
          state_d = CTRL_LO;
          flush_d = flush;
        end else if (flush) begin
          flush_d = 1'b1;
          state_d = (count_next != '0) ? CTRL_LO : DONE;
        end
      end
      CTRL_LO: begin
        out_valid = 1'b1;
        out_data  = ctrl_q[7:0];
        if (hs) state_d = CTRL_HI;
      end
      CTRL_HI: begin
        out_valid = 1'b1;
        out_data  = ctrl_q[15:8];
        if (hs) state_d = ITEM_B0;
      end
      ITEM_B0, ITEM_B1: begin
        out_valid = 1'b1;
        if (state_q == ITEM_B1)   out_data = rd_item.off[7:0];
        else if (rd_item.is_copy) out_data = {rd_item.len, rd_item.off[11:8]};
        else                      out_data = rd_item.lit;
        // A slot is finished on its literal byte or on the second copy byte.
        if ((state_q == ITEM_B1) || !rd_item.is_copy) begin
          out_last = flush_q && last_slot;
          if (hs) begin
            if (!last_slot) begin
              buf_rd_adv = 1'b1;
              state_d    = ITEM_B0;
            end else if (flush_q) begin
              state_d = DONE;
            end else begin
              buf_clear = 1'b1;
              ctrl_d    = '0;
              state_d   = FILL;
            end
          end
        end else if (hs) begin
          state_d = ITEM_B1;
        end
      end
      DONE: ;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hs && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      ctrl_q  <= '0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done          = (state_q == DONE);
  assign bytes_emitted = cnt_q;

endmodule

// File: tb/tb_lzrw1_group_packer.sv
// Directed bench for the LZRW1 group packer.
module tb_lzrw1_group_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        item_valid = 1'b0;
  logic        item_ready;
  logic        item_is_copy = 1'b0;
  logic [3:0]  item_length = '0;
  logic [11:0] item_offset = '0;
  logic [7:0]  item_literal = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic        done;
  logic [15:0] bytes_emitted;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got_data[$];
  logic       got_last[$];
  int         hold_err;
  int         ready_err;
  bit         timed_out;

  always #5 clock = ~clock;

  lzrw1_group_packer #(.CNT_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .item_valid    (item_valid),
    .item_ready    (item_ready),
    .item_is_copy  (item_is_copy),
    .item_length   (item_length),
    .item_offset   (item_offset),
    .item_literal  (item_literal),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .done          (done),
    .bytes_emitted (bytes_emitted)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; item_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
    tick();
  endtask

  task automatic send_item(input bit c, input logic [3:0] l, input logic [11:0] o, input logic [7:0] lit);
    item_valid = 1'b1; item_is_copy = c; item_length = l; item_offset = o; item_literal = lit;
    tick();
    item_valid = 1'b0;
  endtask

  // Gathers n output bytes; stall mode drives out_ready 1,0,1,0,...
  task automatic collect(input int n, input bit stall);
    bit         phase = 1'b1;
    bit         prev_stall = 1'b0;
    logic [7:0] pd = '0;
    logic       pl = 1'b0;
    got_data.delete(); got_last.delete();
    hold_err = 0; ready_err = 0; timed_out = 0;
    for (int cyc = 0; cyc < 400 && got_data.size() < n; cyc++) begin
      out_ready = stall ? phase : 1'b1;
      phase = ~phase;
      if (prev_stall && (out_data !== pd || out_last !== pl)) hold_err++;
      if (out_valid && item_ready) ready_err++;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data; pl = out_last;
      tick();
    end
    out_ready = 1'b1;
    if (got_data.size() < n) timed_out = 1;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b data=%h last=%b done=%b, need 0,00,0,0", out_valid, out_data, out_last, done);
    end
    checks++;
    if (bytes_emitted !== 16'd0) begin
      failures++; $display("FAIL reset_bytes: got %0d need 0", bytes_emitted);
    end
    checks++;
    if (item_ready !== 1'b1) begin
      failures++; $display("FAIL reset_item_ready: got %b need 1", item_ready);
    end
  endtask

  task automatic test_literal_group(input bit stall, input logic [15:0] exp_bytes);
    logic [7:0] exp[18];
    int         lasts = 0;
    exp[0] = 8'h00; exp[1] = 8'h00;
    for (int i = 0; i < 16; i++) exp[i+2] = 8'h41 + 8'(i);
    for (int i = 0; i < 16; i++) send_item(1'b0, 4'h0, 12'h000, 8'h41 + 8'(i));
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h00) begin
      failures++; $display("FAIL lit_latency: valid=%b data=%h need 1,00", out_valid, out_data);
    end
    collect(18, stall);
    checks++;
    if (timed_out) begin
      failures++; $display("FAIL lit_timeout: got %0d bytes need 18", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp[i]) begin
        failures++; $display("FAIL lit_byte[%0d]: got %h need %h", i, got_data[i], exp[i]);
      end
      if (got_last[i] === 1'b1) lasts++;
    end
    checks++;
    if (lasts != 0) begin
      failures++; $display("FAIL lit_no_last: got %0d out_last pulses need 0", lasts);
    end
    checks++;
    if (hold_err != 0 || ready_err != 0) begin
      failures++; $display("FAIL lit_hold_ready: hold_err=%0d ready_err=%0d need 0,0", hold_err, ready_err);
    end
    checks++;
    if (bytes_emitted !== exp_bytes) begin
      failures++; $display("FAIL lit_bytes_emitted: got %0d need %0d", bytes_emitted, exp_bytes);
    end
    checks++;
    if (item_ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL lit_back_to_fill: item_ready=%b done=%b need 1,0", item_ready, done);
    end
  endtask

  task automatic test_copy_group(input logic [15:0] exp_bytes);
    logic [7:0] exp[19];
    exp[0] = 8'h01; exp[1] = 8'h00; exp[2] = 8'h31; exp[3] = 8'h23;
    for (int i = 0; i < 15; i++) exp[i+4] = 8'h61 + 8'(i);
    send_item(1'b1, 4'h3, 12'h123, 8'hEE);
    for (int i = 0; i < 15; i++) send_item(1'b0, 4'hA, 12'hBCD, 8'h61 + 8'(i));
    collect(19, 1'b0);
    checks++;
    if (timed_out) begin
      failures++; $display("FAIL copy_timeout: got %0d bytes need 19", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp[i] || got_last[i] !== 1'b0) begin
        failures++; $display("FAIL copy_byte[%0d]: got %h last=%b need %h last=0", i, got_data[i], got_last[i], exp[i]);
      end
    end
    checks++;
    if (bytes_emitted !== exp_bytes) begin
      failures++; $display("FAIL copy_bytes_emitted: got %0d need %0d", bytes_emitted, exp_bytes);
    end
  endtask

  task automatic test_flush_partial(input logic [15:0] exp_bytes);
    logic [7:0] exp[9] = '{8'h12, 8'h00, 8'h11, 8'h20, 8'hAB, 8'h22, 8'h33, 8'hFF, 8'hFF};
    bit         stray = 0;
    send_item(1'b0, 4'h0, 12'h000, 8'h11);
    send_item(1'b1, 4'h2, 12'h0AB, 8'h00);
    send_item(1'b0, 4'h0, 12'h000, 8'h22);
    send_item(1'b0, 4'h0, 12'h000, 8'h33);
    send_item(1'b1, 4'hF, 12'hFFF, 8'h00);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    collect(9, 1'b0);
    checks++;
    if (timed_out) begin
      failures++; $display("FAIL flush_timeout: got %0d bytes need 9", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp[i] || got_last[i] !== (i == 8)) begin
        failures++; $display("FAIL flush_byte[%0d]: got %h last=%b need %h last=%b", i, got_data[i], got_last[i], exp[i], (i == 8));
      end
    end
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL flush_done: got %b need 1", done);
    end
    for (int i = 0; i < 4; i++) begin
      if (done !== 1'b1 || out_valid !== 1'b0 || item_ready !== 1'b0) stray = 1;
      item_valid = 1'b1;
      tick();
    end
    item_valid = 1'b0;
    checks++;
    if (stray) begin
      failures++; $display("FAIL flush_done_sticky: DONE state not held (done/out_valid/item_ready)");
    end
    checks++;
    if (bytes_emitted !== exp_bytes) begin
      failures++; $display("FAIL flush_bytes_emitted: got %0d need %0d", bytes_emitted, exp_bytes);
    end
  endtask

  task automatic test_flush_empty();
    bit any_valid = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (done !== 1'b1 || item_ready !== 1'b0) begin
      failures++; $display("FAIL empty_done: done=%b item_ready=%b need 1,0", done, item_ready);
    end
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b0) any_valid = 1;
      tick();
    end
    checks++;
    if (any_valid || bytes_emitted !== 16'd0 || done !== 1'b1) begin
      failures++; $display("FAIL empty_no_output: any_valid=%b bytes=%0d done=%b need 0,0,1", any_valid, bytes_emitted, done);
    end
  endtask

  task automatic test_flush_with_accept();
    logic [7:0] exp[3] = '{8'h00, 8'h00, 8'h5A};
    item_valid = 1'b1; item_is_copy = 1'b0; item_literal = 8'h5A; flush = 1'b1;
    tick();
    item_valid = 1'b0; flush = 1'b0;
    collect(3, 1'b0);
    checks++;
    if (timed_out) begin
      failures++; $display("FAIL same_cycle_timeout: got %0d bytes need 3", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp[i] || got_last[i] !== (i == 2)) begin
        failures++; $display("FAIL same_cycle_byte[%0d]: got %h last=%b need %h last=%b", i, got_data[i], got_last[i], exp[i], (i == 2));
      end
    end
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL same_cycle_done: got %b need 1", done);
    end
  endtask

  task automatic test_reset_mid_drain();
    send_item(1'b1, 4'h3, 12'h123, 8'h00);
    for (int i = 0; i < 15; i++) send_item(1'b0, 4'h0, 12'h000, 8'h61 + 8'(i));
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h00 || bytes_emitted !== 16'd1) begin
      failures++; $display("FAIL mid_ctrl_hi: valid=%b data=%h bytes=%0d need 1,00,1", out_valid, out_data, bytes_emitted);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || bytes_emitted !== 16'd0 || item_ready !== 1'b1) begin
      failures++; $display("FAIL mid_reset_outputs: valid=%b data=%h bytes=%0d ready=%b need 0,00,0,1", out_valid, out_data, bytes_emitted, item_ready);
    end
    @(posedge clock);
    #4;
    reset = 1'b1;
    tick();
    test_copy_group(16'd19);
  endtask

  initial begin
    do_reset();
    test_reset();
    test_literal_group(1'b0, 16'd18);
    test_copy_group(16'd37);
    do_reset();
    test_literal_group(1'b1, 16'd18);
    test_flush_partial(16'd27);
    do_reset();
    test_flush_empty();
    do_reset();
    test_flush_with_accept();
    do_reset();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
